fa_with_ha: RTL and testbench
=============================

// Module: fa_with_ha
// PURPOSE
// - Full adder built structurally from two half adders plus an OR gate.
// - Generalised to a WIDTH-bit ripple-carry adder: one half-adder pair per bit.
// - Combinational sum/carry_out for datapath use.
// - Optional registered copy (sum_q/carry_out_q) for pipelined consumers in the arithmetic datapath.
// PARAMETERS
// - WIDTH  1  operand width in bits; must be >= 1.
// PORTS
// - clk          in   1      rising-edge clock; used only by the output register.
// - rst_n        in   1      reset, asynchronous, active-low.
// - a            in   WIDTH  operand A.
// - b            in   WIDTH  operand B.
// - carry_in     in   1      carry into bit 0.
// - sum          out  WIDTH  combinational sum, a+b+carry_in mod 2^WIDTH.
// - carry_out    out  1      combinational carry out of MSB.
// - en           in   1      capture enable for the output register.
// - sum_q        out  WIDTH  registered sum.
// - carry_out_q  out  1      registered carry_out.
// - Interface: one clock (clk); reset rst_n is asynchronous and active-low.
// - Declaration order is a, b, carry_in, sum, carry_out, clk, rst_n, en, sum_q, carry_out_q.
//   - Existing positional 5-port instantiations keep working.
//   - Unconnected clk/rst_n/en leave the combinational path unaffected.
// BEHAVIOUR
// - Half adder (internal submodule ha):
//   - s = x ^ y
//   - c = x & y
// - Per bit i, with c[0] = carry_in:
//   - HA1(a[i], b[i]) -> p, g1
//   - HA2(p, c[i]) -> sum[i], g2
//   - c[i+1] = g1 | g2
//   - carry_out = c[WIDTH]
// - Combinational path:
//   - Zero latency; no dependence on clk, rst_n or en.
//   - Outputs settle after each input change.
// - Arithmetic: {carry_out, sum} == a + b + carry_in exactly (WIDTH+1 bits, unsigned).
//   - Overflow is reported only via carry_out; no saturation.
// - Register path:
//   - rst_n low (async, any time) -> sum_q = 0, carry_out_q = 0 immediately.
//   - Values are held while rst_n is low.
//   - On rising clk with rst_n high and en=1, sum_q/carry_out_q <= sum/carry_out (1-cycle latency).
//   - en=0 holds the previous value.
//   - Reset deasserting coincident with a clk edge: no capture on that edge.
// - No X propagation on known inputs; no latches; no internal state other than the output register.
// TESTING
// - WIDTH=1, a=0 b=0 cin=1 -> sum=1 carry_out=0.
// - Then b=1 (a=0 cin=1) -> sum=0 carry_out=1.
// - Then a=1 (b=1 cin=1) -> sum=1 carry_out=1.
// - Then a=0 b=0 cin=0 -> sum=0 carry_out=0.
// - Exhaustive check: all 8 input combos at WIDTH=1, and random plus corner vectors at WIDTH=8:
//   - 0xFF+0x00+1 -> sum=0x00 carry_out=1.
//   - 0x80+0x80+0 -> sum=0x00 carry_out=1.
//   - All must match a+b+cin.
// - Register path:
//   - rst_n=0 -> sum_q=0 carry_out_q=0 without a clock edge.
//   - Release reset; en=1 with a=1 b=1 cin=0 -> after one clk edge sum_q=0 carry_out_q=1.
//   - en=0 with new inputs -> sum_q/carry_out_q unchanged.
//   - Assert rst_n mid-run -> outputs clear asynchronously.

Source files
------------

// File: rtl/fa_with_ha_if.sv
// Operand/result bundle for the fa_with_ha ripple adder.
// The master drives the operands and carry_in; the slave returns sum and carry_out.
interface fa_with_ha_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    // No valid/ready here: the adder is purely combinational, so every change
    // on a/b/carry_in is reflected on sum/carry_out in the same cycle.
    modport master (
        output a,
        output b,
        output carry_in,
        input  sum,
        input  carry_out
    );

    modport slave (
        input  a,
        input  b,
        input  carry_in,
        output sum,
        output carry_out
    );
endinterface

// File: rtl/fa_with_ha.sv
// WIDTH-bit ripple-carry adder: each bit is two half adders plus an OR gate.
// Provides a combinational result and an enable-gated registered copy.
module ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module fa_with_ha #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_out_q
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen1;
    logic [WIDTH-1:0] gen2;

    logic [WIDTH-1:0] sum_d;
    logic             carry_out_d;

    assign carry[0] = carry_in;

    // Bit i: HA1 forms propagate/generate, HA2 folds in the incoming carry.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ha u_ha1 (
            .x (a[i]),
            .y (b[i]),
            .s (prop[i]),
            .c (gen1[i])
        );

        ha u_ha2 (
            .x (prop[i]),
            .y (carry[i]),
            .s (sum[i]),
            .c (gen2[i])
        );

        assign carry[i+1] = gen1[i] | gen2[i];
    end

    assign carry_out = carry[WIDTH];

    always_comb begin
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        if (en) begin
            sum_d       = sum;
            carry_out_d = carry_out;
        end
    end

    // Async clear; a reset released on the same edge as clk captures nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
        end
    end
endmodule

// File: tb/tb_fa_with_ha.sv
// Scoreboard bench for fa_with_ha at WIDTH=1 and WIDTH=8, combinational and registered paths.
module tb_fa_with_ha;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en;
  logic mon_valid;

  logic       q1;
  logic       q1_co;
  logic [7:0] q8;
  logic       q8_co;

  fa_with_ha_if #(.WIDTH(1)) if1 ();
  fa_with_ha_if #(.WIDTH(8)) if8 ();

  fa_with_ha #(.WIDTH(1)) u_dut1 (
    .a           (if1.a),
    .b           (if1.b),
    .carry_in    (if1.carry_in),
    .sum         (if1.sum),
    .carry_out   (if1.carry_out),
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sum_q       (q1),
    .carry_out_q (q1_co)
  );

  fa_with_ha #(.WIDTH(8)) u_dut8 (
    .a           (if8.a),
    .b           (if8.b),
    .carry_in    (if8.carry_in),
    .sum         (if8.sum),
    .carry_out   (if8.carry_out),
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sum_q       (q8),
    .carry_out_q (q8_co)
  );

  // kind: 0 = comb W1, 1 = comb W8, 2 = reg W1, 3 = reg W8; val = {carry, sum}
  typedef struct {
    int         kind;
    logic [8:0] val;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // ---------------- driver tasks ----------------
  task automatic push(input int kind, input logic [8:0] val, input string tag);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic strobe();
    mon_valid = 1'b1;
    #1;
    mon_valid = 1'b0;
  endtask

  task automatic drive1(input logic a, input logic b, input logic c);
    if1.a        = a;
    if1.b        = b;
    if1.carry_in = c;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c);
    if8.a        = a;
    if8.b        = b;
    if8.carry_in = c;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge mon_valid) begin
    while (exp_q.size() > 0) begin
      exp_t       e;
      logic [8:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        0:       act = {7'b0, if1.carry_out, if1.sum};
        1:       act = {if8.carry_out, if8.sum};
        2:       act = {7'b0, q1_co, q1};
        default: act = {q8_co, q8};
      endcase
      n_checks++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got {carry,sum}=0x%03h expected 0x%03h at %0t", e.tag, act, e.val, $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0] exp1_tab [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
  logic [7:0] va [10]  = '{8'hFF, 8'h80, 8'h00, 8'hFF, 8'h0F, 8'h55, 8'h55, 8'h7F, 8'h12, 8'hFE};
  logic [7:0] vb [10]  = '{8'h00, 8'h80, 8'h00, 8'hFF, 8'h01, 8'hAA, 8'hAA, 8'h01, 8'h34, 8'h01};
  logic       vc [10]  = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
  logic [8:0] vexp [10] = '{9'h100, 9'h100, 9'h000, 9'h1FF, 9'h010, 9'h0FF, 9'h100, 9'h080, 9'h047, 9'h0FF};

  initial begin
    logic [2:0] v;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] rsum;

    mon_valid = 1'b0;
    rst_n     = 1'b0;
    en        = 1'b0;
    drive1(1'b0, 1'b0, 1'b0);
    drive8(8'h00, 8'h00, 1'b0);

    // Reset state before any clock edge
    #3;
    push(2, 9'h000, "reset_q_w1");
    push(3, 9'h000, "reset_q_w8");
    push(0, 9'h000, "reset_comb_w1");
    push(1, 9'h000, "reset_comb_w8");
    strobe();

    // Directed WIDTH=1 sequence
    drive1(1'b0, 1'b0, 1'b1); #1; push(0, 9'h001, "seq_a0b0c1"); strobe();
    drive1(1'b0, 1'b1, 1'b1); #1; push(0, 9'h002, "seq_a0b1c1"); strobe();
    drive1(1'b1, 1'b1, 1'b1); #1; push(0, 9'h003, "seq_a1b1c1"); strobe();
    drive1(1'b0, 1'b0, 1'b0); #1; push(0, 9'h000, "seq_a0b0c0"); strobe();

    // Exhaustive WIDTH=1, index = {a,b,cin}
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive1(v[2], v[1], v[0]);
      #1;
      push(0, {7'b0, exp1_tab[i]}, $sformatf("exh_w1_%0d", i));
      strobe();
    end

    // WIDTH=8 corners
    for (int i = 0; i < 10; i++) begin
      drive8(va[i], vb[i], vc[i]);
      #1;
      push(1, vexp[i], $sformatf("vec_w8_%0d", i));
      strobe();
    end

    // WIDTH=8 random against a plain integer sum
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rsum = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      drive8(ra, rb, rc);
      #1;
      push(1, rsum, $sformatf("rnd_w8_%0d", i));
      strobe();
    end

    // Register held at zero while reset is low, even with en=1
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    push(2, 9'h000, "hold_in_reset_w1");
    push(3, 9'h000, "hold_in_reset_w8");
    strobe();

    // Release reset, capture 1+1+0
    @(negedge clk);
    rst_n = 1'b1;
    drive1(1'b1, 1'b1, 1'b0);
    drive8(8'h01, 8'h01, 1'b0);
    @(posedge clk); #1;
    push(2, 9'h002, "capture_w1");
    push(3, 9'h002, "capture_w8");
    strobe();

    // en=0 holds despite new inputs
    @(negedge clk);
    en = 1'b0;
    drive1(1'b1, 1'b0, 1'b0);
    drive8(8'hFF, 8'h00, 1'b1);
    @(posedge clk); #1;
    push(2, 9'h002, "en0_hold_w1");
    push(3, 9'h002, "en0_hold_w8");
    push(1, 9'h100, "en0_comb_w8");
    strobe();

    // en=1 again picks up the waiting inputs
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    push(2, 9'h001, "recapture_w1");
    push(3, 9'h100, "recapture_w8");
    strobe();

    @(negedge clk);
    drive1(1'b0, 1'b1, 1'b1);
    drive8(8'h55, 8'hAA, 1'b0);
    @(posedge clk); #1;
    push(2, 9'h002, "capture2_w1");
    push(3, 9'h0FF, "capture2_w8");
    strobe();

    // Mid-cycle async reset clears without a clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push(2, 9'h000, "async_clr_w1");
    push(3, 9'h000, "async_clr_w8");
    push(1, 9'h0FF, "comb_in_reset_w8");
    strobe();

    @(posedge clk); #1;
    push(2, 9'h000, "held_clr_w1");
    push(3, 9'h000, "held_clr_w8");
    strobe();

    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
